div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Iterative 32-bit divider for the EX stage; handles DIV and DIVU.
//  Sits beside the ALU and consumes the 8-bit alucontrol code from aludec
//  (`EXE_DIV_OP / `EXE_DIVU_OP from defines.vh).
//  Produces {HI=remainder, LO=quotient} for the HI/LO register file.
//  Holds the pipeline through a stall output while a division is in flight.
// PARAMETERS
//  WIDTH  32  operand width; the iteration count equals WIDTH.
// PORTS
//  clk         in   1        clock; all state updates on the rising edge
//  rst         in   1        synchronous, active-low reset
//  alucontrol  in   8        EX-stage ALU op; only `EXE_DIV_OP / `EXE_DIVU_OP start work
//  start       in   1        EX-stage instruction valid (not a bubble)
//  annul       in   1        flush; abandons any division in progress
//  srca        in   WIDTH    dividend (rs)
//  srcb        in   WIDTH    divisor (rt)
//  result      out  2*WIDTH  {remainder[63:32], quotient[31:0]}
//  ready       out  1        one-cycle pulse; result is valid this cycle
//  stall       out  1        request to freeze IF/ID/EX while a division is in flight
// BEHAVIOUR
//  Reset: rst==0 at an edge forces state IDLE and clears result, ready and
//   count to 0. stall reads 0 in IDLE. Reset applies in any state, including
//   mid-division.
//  Accept condition: state==IDLE, start=1, annul=0, and alucontrol is a divide op.
//   On accept, srca/srcb and the signed flag (DIV) are latched.
//   Operands are never re-sampled after accept.
//  FSM states: IDLE, BUSY, DZERO, DONE.
//   IDLE : accept with srcb!=0 -> BUSY, count=0. Accept with srcb==0 -> DZERO.
//   BUSY : one restoring-division step per cycle on magnitudes.
//          Shift {rem,quo} left by 1. If rem>=|b|, subtract |b| and set quo LSB to 1.
//          count++. After step WIDTH (count==WIDTH-1) -> DONE.
//   DZERO: one cycle, result=0 -> DONE. Dividing by zero is not an error.
//   DONE : ready=1 for exactly one cycle, result held -> IDLE.
//  Signed handling (DIV):
//   Operands are converted to magnitudes on accept.
//   Quotient is negated if the operand signs differ.
//   Remainder takes the sign of the dividend.
//   0x80000000 / -1 yields LO=0x80000000, HI=0 with no trap.
//  DIVU: operands are treated as unsigned and no sign fix-up is applied.
//  stall = (IDLE and accept condition) | BUSY | DZERO.
//   stall is 0 in DONE, so the pipeline advances in the same cycle the result is consumed.
//  Latency (edge 0 = accept edge):
//   Normal division: ready is high between edges WIDTH+1 and WIDTH+2 (33-34).
//   Divide by zero: ready is high between edges 2 and 3.
//  annul=1 in BUSY/DZERO/DONE -> IDLE at the next edge; no ready pulse; result unchanged.
//   annul overrides start in IDLE, so no accept happens.
//  result holds its last value until the next DONE. ready is never asserted outside DONE.
//  Non-divide alucontrol codes, or start=0, leave the block in IDLE with stall=0.
// TESTING
//  1. DIVU 100/7, accept at edge 0 -> ready pulse in cycle 33; result = {32'd2, 32'd14}.
//     stall stays high in cycles 0-32.
//  2. DIV -7/2 (0xFFFFFFF9/2) -> result = {32'hFFFFFFFF, 32'hFFFFFFFD}.
//     DIV 7/-2 -> {32'd1, 32'hFFFFFFFD}.
//  3. DIV 0x80000000/0xFFFFFFFF -> {32'h0, 32'h80000000}.
//     DIVU 0xFFFFFFFF/1 -> {32'h0, 32'hFFFFFFFF}.
//  4. DIVU 5/0 -> ready in cycle 2, result = 0; stall high in cycles 0-1 only.
//  5. annul at cycle 10 of a DIV -> IDLE at the next edge; no ready; stall=0.
//     A new DIVU 9/3 is then accepted and gives {0, 3}.
//  6. rst=0 at cycle 15 mid-division -> result=0, ready=0, stall=0 at the next edge.
//     An ADD alucontrol with start=1 never raises stall.

Source files
------------

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH steps and stalls the pipeline while busy.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         alucontrol,
    input  logic               start,
    input  logic               annul,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall
);
    localparam logic [7:0] DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP = 8'b0001_1011;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DZERO, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic             neg_q, neg_r;
    logic [CW-1:0]    count;

    logic             is_sgn, accept, last, fits;
    logic [WIDTH-1:0] abs_a, abs_b, rem_nx, quo_nx, q_fix, r_fix;
    logic [WIDTH:0]   trial;

    assign is_sgn = (alucontrol == DIV_OP);
    assign accept = (state == IDLE) && start && !annul &&
                    ((alucontrol == DIV_OP) || (alucontrol == DIVU_OP));
    assign abs_a  = (is_sgn && srca[WIDTH-1]) ? -srca : srca;
    assign abs_b  = (is_sgn && srcb[WIDTH-1]) ? -srcb : srcb;

    // Shifted partial remainder carries one extra bit so a full-range unsigned divisor still fits.
    assign trial  = {rem, quo[WIDTH-1]};
    assign fits   = (trial >= {1'b0, dvs});
    assign rem_nx = fits ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
    assign quo_nx = {quo[WIDTH-2:0], fits};
    assign q_fix  = neg_q ? -quo_nx : quo_nx;
    assign r_fix  = neg_r ? -rem_nx : rem_nx;
    assign last   = (count == CW'(WIDTH - 1));

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        ready    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall    = 1'b1;
                    state_nx = (srcb == '0) ? DZERO : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (annul)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DZERO: begin
                stall    = 1'b1;
                state_nx = annul ? IDLE : DONE;
            end
            DONE: begin
                ready    = !annul;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            result <= '0;
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem   <= '0;
                        quo   <= abs_a;
                        dvs   <= abs_b;
                        neg_q <= is_sgn && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        neg_r <= is_sgn && srca[WIDTH-1];
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (!annul) begin
                        rem   <= rem_nx;
                        quo   <= quo_nx;
                        count <= count + 1'b1;
                        if (last) result <= {r_fix, q_fix};
                    end
                end
                DZERO: begin
                    if (!annul) result <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
